// File: rtl/fsqrt_iter.sv
// Multi-cycle binary32 square root, radix-2 restoring digit recurrence.
// BPC root bits per cycle; correctly rounded (RNE/RTZ), one operation in flight.
module fsqrt_iter #(
   parameter int unsigned BPC = 1
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [31:0] x_i,
   input  logic        rm_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic        flush_i,
   output logic [31:0] y_o,
   output logic        nv_o,
   output logic        nx_o,
   output logic        out_valid_o,
   input  logic        out_ready_i
);

   localparam int unsigned ITER = (25 + BPC - 1) / BPC;
   localparam int unsigned NB   = ITER * BPC;  // root bits computed, >= 25
   localparam int unsigned RW   = 2 * NB;
   localparam int unsigned MW   = NB + 3;
   localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [31:0] QNaN = 32'h7FC0_0000;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   rad_q, rad_n, rad_init;
   logic [MW-1:0]   rem_q, rem_n, trial;
   logic [NB-1:0]   root_q, root_n, low;
   logic [7:0]      exp_q, exp_init;
   logic            rm_q;
   logic            spec_q, spec_d;
   logic [31:0]     spec_y_q, spec_y_d;
   logic            spec_nv_q, spec_nv_d;
   logic [31:0]     y_q, norm_y;
   logic            nv_q, nx_q;
   logic            load, step, finish;
   logic [7:0]      ex;
   logic [22:0]     fr;
   logic            odd;
   logic [24:0]     q25, sum;
   logic            guard, sticky, inc;

   // Operand unpack and special-case classification.
   always_comb begin
      ex        = x_i[30:23];
      fr        = x_i[22:0];
      odd       = ~ex[0];
      rad_init  = odd ? (RW'({1'b1, fr}) << (RW - 24)) : (RW'({1'b1, fr}) << (RW - 25));
      exp_init  = 8'((9'(ex) + 9'd127 - {8'd0, odd}) >> 1);
      spec_d    = 1'b1;
      spec_y_d  = '0;
      spec_nv_d = 1'b0;
      if (ex == 8'd0) begin
         spec_y_d = {x_i[31], 31'd0};
      end else if (ex == 8'hFF && fr != 23'd0) begin
         spec_y_d = QNaN;
      end else if (x_i[31]) begin
         spec_y_d  = QNaN;
         spec_nv_d = 1'b1;
      end else if (ex == 8'hFF) begin
         spec_y_d = 32'h7F80_0000;
      end else begin
         spec_d = 1'b0;
      end
   end

   // BPC recurrence steps: bring down two radicand bits, try (root<<2)|1.
   always_comb begin
      rad_n  = rad_q;
      rem_n  = rem_q;
      root_n = root_q;
      trial  = '0;
      for (int i = 0; i < int'(BPC); i++) begin
         rem_n = {rem_n[MW-3:0], rad_n[RW-1 -: 2]};
         trial = {1'b0, root_n, 2'b01};
         if (rem_n >= trial) begin
            rem_n  = rem_n - trial;
            root_n = {root_n[NB-2:0], 1'b1};
         end else begin
            root_n = {root_n[NB-2:0], 1'b0};
         end
         rad_n = {rad_n[RW-3:0], 2'b00};
      end
   end

   // Rounding on the final step's root; surplus root bits fold into sticky.
   always_comb begin
      q25    = root_n[NB-1 -: 25];
      low    = root_n << 25;
      guard  = q25[0];
      sticky = (|low) | (|rem_n);
      inc    = ~rm_q & guard & (sticky | q25[1]);
      sum    = {1'b0, q25[24:1]} + {24'd0, inc};
      // Hidden bit of sum lands in the exponent field, a carry bumps it once more.
      norm_y = {1'b0, exp_q - 8'd1, 23'd0} + {7'd0, sum};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      case (state_q)
         StIdle: begin
            if (in_valid_i && !flush_i) begin
               state_d = StCalc;
               cnt_d   = '0;
               load    = 1'b1;
            end
         end
         StCalc: begin
            if (flush_i) begin
               state_d = StIdle;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(ITER - 1)) begin
                  finish  = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (flush_i || out_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rad_q     <= '0;
         rem_q     <= '0;
         root_q    <= '0;
         exp_q     <= '0;
         rm_q      <= 1'b0;
         spec_q    <= 1'b0;
         spec_y_q  <= '0;
         spec_nv_q <= 1'b0;
         y_q       <= '0;
         nv_q      <= 1'b0;
         nx_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            rad_q     <= rad_init;
            rem_q     <= '0;
            root_q    <= '0;
            exp_q     <= exp_init;
            rm_q      <= rm_i;
            spec_q    <= spec_d;
            spec_y_q  <= spec_y_d;
            spec_nv_q <= spec_nv_d;
         end else if (step) begin
            rad_q  <= rad_n;
            rem_q  <= rem_n;
            root_q <= root_n;
         end
         if (finish) begin
            y_q  <= spec_q ? spec_y_q : norm_y;
            nv_q <= spec_q & spec_nv_q;
            nx_q <= ~spec_q & (guard | sticky);
         end
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StDone);
   assign y_o         = y_q;
   assign nv_o        = nv_q;
   assign nx_o        = nx_q;

endmodule

// File: tb/tb_fsqrt_iter.sv
// Bench for fsqrt_iter: BPC=1 and BPC=5 instances in lockstep, scoreboard against
// a double-precision reference rounded to binary32.
module tb_fsqrt_iter;

   typedef struct {
      logic [31:0] y;
      logic        nv;
      logic        nx;
   } res_t;

   typedef struct {
      logic [31:0] x;
      logic        rm;
      logic [31:0] y;
      logic        nv;
      logic        nx;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] x = '0;
   logic        rm = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] y1, y5;
   logic        nv1, nx1, ov1, ir1, nv5, nx5, ov5, ir5;

   int   nvec = 0;
   int   nerr = 0;
   res_t exp_q[$];
   logic [31:0] last_y = '0;

   always #5 clk = ~clk;

   fsqrt_iter #(.BPC(1)) dut (
      .clk_i(clk), .rstn_i(rstn), .x_i(x), .rm_i(rm), .in_valid_i(in_valid),
      .in_ready_o(ir1), .flush_i(flush), .y_o(y1), .nv_o(nv1), .nx_o(nx1),
      .out_valid_o(ov1), .out_ready_i(out_ready)
   );

   // Held in DONE until the BPC=1 unit is also done, so both stay in step.
   fsqrt_iter #(.BPC(5)) dut5 (
      .clk_i(clk), .rstn_i(rstn), .x_i(x), .rm_i(rm), .in_valid_i(in_valid),
      .in_ready_o(ir5), .flush_i(flush), .y_o(y5), .nv_o(nv5), .nx_o(nx5),
      .out_valid_o(ov5), .out_ready_i(out_ready & ov1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [63:0] f2d(input logic [31:0] f);
      return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
   endfunction

   function automatic res_t model(input logic [31:0] a, input logic r);
      res_t        o;
      logic [7:0]  e;
      logic [22:0] f;
      logic [63:0] rb;
      logic [31:0] fb;
      real         v, rt, yd;
      e = a[30:23];
      f = a[22:0];
      o.y = '0; o.nv = 1'b0; o.nx = 1'b0;
      if (e == 8'd0) o.y = {a[31], 31'd0};
      else if (e == 8'hFF && f != 0) o.y = 32'h7FC0_0000;
      else if (a[31]) begin o.y = 32'h7FC0_0000; o.nv = 1'b1; end
      else if (e == 8'hFF) o.y = 32'h7F80_0000;
      else begin
         v  = $bitstoreal(f2d(a));
         rt = $sqrt(v);
         rb = $realtobits(rt);
         fb = {1'b0, 8'(rb[62:52] - 11'd896), rb[51:29]};
         if (rb[28] && ((|rb[27:0]) || fb[0])) fb = fb + 32'd1;
         yd = $bitstoreal(f2d(fb));
         if (r && (yd * yd > v)) begin
            fb = fb - 32'd1;
            yd = $bitstoreal(f2d(fb));
         end
         o.y  = fb;
         o.nx = (yd * yd != v);
      end
      return o;
   endfunction

   // Scoreboard: every delivered result is popped and compared on both units.
   always @(negedge clk) begin
      res_t e;
      if (rstn && ov1 && out_ready) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL spurious_result: got y=%h with no result pending", y1);
         end else begin
            e = exp_q.pop_front();
            check("y", y1, e.y);
            check("nv", {31'd0, nv1}, {31'd0, e.nv});
            check("nx", {31'd0, nx1}, {31'd0, e.nx});
            check("valid_bpc5", {31'd0, ov5}, 32'd1);
            check("y_bpc5", y5, e.y);
            check("flags_bpc5", {30'd0, nv5, nx5}, {30'd0, e.nv, e.nx});
            last_y = e.y;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a, input logic r, input bit push, input res_t e);
      int n = 0;
      if (push) exp_q.push_back(e);
      x = a;
      rm = r;
      in_valid = 1'b1;
      while (!ir1 && n < 200) begin
         tick();
         n++;
      end
      if (!ir1) check("accept_timeout", {31'd0, ir1}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !ir1) && n < 500) begin
         tick();
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   vec_t vt[$];
   res_t r0;
   int   lat, lat5;
   bit   saw;
   logic [31:0] xr;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt.push_back('{32'h4110_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0});
      vt.push_back('{32'h3E80_0000, 1'b0, 32'h3F00_0000, 1'b0, 1'b0});
      vt.push_back('{32'h4000_0000, 1'b0, 32'h3FB5_04F3, 1'b0, 1'b1});
      vt.push_back('{32'h4000_0000, 1'b1, 32'h3FB5_04F3, 1'b0, 1'b1});
      vt.push_back('{32'h3F80_0000, 1'b1, 32'h3F80_0000, 1'b0, 1'b0});
      vt.push_back('{32'hBF80_0000, 1'b0, 32'h7FC0_0000, 1'b1, 1'b0});
      vt.push_back('{32'h7F80_0000, 1'b0, 32'h7F80_0000, 1'b0, 1'b0});
      vt.push_back('{32'h7FC1_2345, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0});
      vt.push_back('{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0});
      vt.push_back('{32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
      vt.push_back('{32'hFF80_0000, 1'b1, 32'h7FC0_0000, 1'b1, 1'b0});

      #3;
      check("rst_y", y1, 32'd0);
      check("rst_valid", {30'd0, ov1, ov5}, 32'd0);
      check("rst_ready", {30'd0, ir1, ir5}, 32'd3);
      check("rst_flags", {30'd0, nv1, nx1}, 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      // Latency and backpressure on 4.0.
      out_ready = 1'b0;
      send(32'h4080_0000, 1'b0, 1'b1, '{32'h4000_0000, 1'b0, 1'b0});
      lat = 0;
      lat5 = 0;
      while (!ov1 && lat < 60) begin
         if (ov5 && lat5 == 0) lat5 = lat;
         tick();
         lat++;
      end
      check("latency_bpc1", lat, 25);
      check("latency_bpc5", lat5, 5);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", {31'd0, ov1}, 32'd1);
         check("hold_y", y1, 32'h4000_0000);
         check("hold_ready", {31'd0, ir1}, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      check("idle_after_ready", {31'd0, ir1}, 32'd1);

      foreach (vt[i]) begin
         r0 = '{vt[i].y, vt[i].nv, vt[i].nx};
         send(vt[i].x, vt[i].rm, 1'b1, r0);
      end
      drain();

      // Back-to-back operations.
      for (int i = 0; i < 6; i++) begin
         xr = {1'b0, 8'(8'd100 + 8'(i * 7)), 23'($urandom)};
         send(xr, i[0], 1'b1, model(xr, i[0]));
      end
      drain();

      // Flush in the third CALC cycle.
      send(32'h4110_0000, 1'b0, 1'b0, r0);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_idle", {31'd0, ir1}, 32'd1);
      check("flush_y", y1, last_y);
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (ov1 || ov5) saw = 1'b1;
         tick();
      end
      check("flush_no_result", {31'd0, saw}, 32'd0);

      // Flush in IDLE suppresses the accept.
      flush = 1'b1;
      in_valid = 1'b1;
      x = 32'h4080_0000;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_idle_no_accept", {30'd0, ir1, ir5}, 32'd3);

      // Asynchronous reset mid-calculation.
      send(32'h4110_0000, 1'b0, 1'b0, r0);
      repeat (5) tick();
      rstn = 1'b0;
      #1;
      check("areset_y", y1, 32'd0);
      check("areset_valid", {30'd0, ov1, ov5}, 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      // Random sweep: every exponent, both rounding modes.
      for (int i = 0; i < 1016; i++) begin
         xr = {1'b0, 8'(1 + (i / 4) % 254), 23'($urandom)};
         if (i % 97 == 5) xr[22:0] = 23'h7F_FFFF;
         send(xr, i[0], 1'b1, model(xr, i[0]));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
